nn_host_sequencer: RTL and testbench

- Host-side initiator for the neural-network core's byte-serial load/read protocol.
- Accepts a valid/ready byte stream: 24 parameter bytes, then 4 input bytes.
- Presents each byte to the core with a write strobe and issues the one-cycle `changes` pulses that step the core's 2-bit phase machine.
- Reads back the four neuron outputs through the output selector and returns them as one 32-bit result.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/nn_byte_feeder.sv | 43 ++++
 rtl/nn_host_sequencer.sv | 147 ++++++++++++++
 tb/tb_nn_host_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and constants for the NN host sequencer.
// Holds the FSM state enum, core phase codes and default byte counts.
package nn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_P,
    S_STEP_P,
    S_LOAD_I,
    S_STEP_I,
    S_SETTLE,
    S_SEL,
    S_CAP,
    S_RETURN,
    S_DONE
  } state_t;

  localparam logic [1:0] NN_PHASE_PARAM   = 2'd0;
  localparam logic [1:0] NN_PHASE_INPUT   = 2'd1;
  localparam logic [1:0] NN_PHASE_COMPUTE = 2'd2;
  localparam logic [1:0] NN_PHASE_OUTPUT  = 2'd3;

  localparam int NN_PARAM_BYTES = 24;
  localparam int NN_INPUT_BYTES = 4;
  localparam int NN_OUTPUTS     = 4;
  localparam int NN_SETTLE      = 2;
  localparam int NN_CNT_W       = 5;

endpackage

// File: rtl/nn_byte_feeder.sv
// Valid/ready byte acceptor feeding the core data bus.
// Ports: en/n_bytes (load window and length), in_* (upstream
// stream), nn_data/nn_we (registered byte + strobe), last (final
// accept of the window, counter wraps to 0).
module nn_byte_feeder
  import nn_pkg::*;
#(
  parameter int CW = NN_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CW-1:0] n_bytes,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [7:0]    nn_data,
  output logic          nn_we,
  output logic          last
);

  logic [CW-1:0] cnt;
  logic          accept;

  assign in_ready = en;
  assign accept   = en & in_valid;
  assign last     = accept & (cnt == n_bytes - CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      nn_data <= 8'h00;
      nn_we   <= 1'b0;
    end else begin
      nn_we <= accept;
      if (accept) begin
        nn_data <= in_data;
        cnt     <= last ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nn_host_sequencer.sv
// Host-side sequencer: streams params/inputs into the NN core,
// steps its phase machine, reads back four outputs.
// Ports: start, in_valid/in_data/in_ready (byte stream),
// nn_data/nn_we/nn_changes/nn_sel/nn_out (core side),
// busy, done, res_valid/res_data (32-bit result).
module nn_host_sequencer
  import nn_pkg::*;
#(
  parameter int N_PARAM_BYTES = NN_PARAM_BYTES,
  parameter int N_INPUT_BYTES = NN_INPUT_BYTES,
  parameter int N_OUTPUTS     = NN_OUTPUTS,
  parameter int SETTLE_CYCLES = NN_SETTLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  nn_data,
  output logic        nn_we,
  output logic        nn_changes,
  output logic [1:0]  nn_sel,
  input  logic [7:0]  nn_out,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        done
);

  state_t state, next;

  logic [3:0]  wait_cnt;
  logic [1:0]  k;
  logic [1:0]  mirror;
  logic        gap;
  logic [31:0] cap;

  logic                feed_en;
  logic                last;
  logic [NN_CNT_W-1:0] n_bytes;
  logic                pulse_req;
  logic                step;

  assign n_bytes = (state == S_LOAD_I)
                 ? NN_CNT_W'(N_INPUT_BYTES)
                 : NN_CNT_W'(N_PARAM_BYTES);

  nn_byte_feeder #(.CW(NN_CNT_W)) u_feed (
    .clk      (clk),
    .reset    (reset),
    .en       (feed_en),
    .n_bytes  (n_bytes),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .nn_data  (nn_data),
    .nn_we    (nn_we),
    .last     (last)
  );

  assign nn_sel = (state == S_SEL || state == S_CAP)
                ? k : 2'b00;

  // RETURN alternates pulse / idle so the core sees each
  // phase step as a distinct pulse.
  always_comb begin
    next      = state;
    feed_en   = 1'b0;
    pulse_req = 1'b0;
    unique case (state)
      S_IDLE:   if (start) next = S_LOAD_P;
      S_LOAD_P: begin
        feed_en = 1'b1;
        if (last) next = S_STEP_P;
      end
      S_STEP_P: next = S_LOAD_I;
      S_LOAD_I: begin
        feed_en = 1'b1;
        if (last) next = S_STEP_I;
      end
      S_STEP_I: next = S_SETTLE;
      S_SETTLE: begin
        if (wait_cnt == 4'(SETTLE_CYCLES - 1))
          next = S_SEL;
      end
      S_SEL:    next = S_CAP;
      S_CAP: begin
        if (k == 2'(N_OUTPUTS - 1)) next = S_RETURN;
        else                        next = S_SEL;
      end
      S_RETURN: begin
        if (mirror == NN_PHASE_PARAM) next = S_DONE;
        else if (!gap)                pulse_req = 1'b1;
      end
      S_DONE:   next = S_IDLE;
      default:  next = S_IDLE;
    endcase
  end

  assign step = (state == S_STEP_P) | (state == S_STEP_I)
              | pulse_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      k          <= '0;
      mirror     <= NN_PHASE_PARAM;
      gap        <= 1'b0;
      cap        <= '0;
      nn_changes <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next;
      nn_changes <= step;
      gap        <= pulse_req;
      res_valid  <= (state == S_DONE);
      if (step) mirror <= mirror + 2'd1;
      if (state == S_IDLE && start) begin
        busy <= 1'b1;
        done <= 1'b0;
      end
      if (state == S_SETTLE) begin
        if (next == S_SEL) begin
          wait_cnt <= '0;
          k        <= '0;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end
      if (state == S_CAP) begin
        cap[{k, 3'b000} +: 8] <= nn_out;
        if (next == S_SEL) k <= k + 2'd1;
      end
      if (state == S_DONE) begin
        res_data <= cap;
        busy     <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nn_host_sequencer.sv
// Scoreboard bench for nn_host_sequencer.
// Stimulus pushes expectations; a negedge monitor pops them.
module tb_nn_host_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, nn_we, nn_changes;
  logic [7:0]  nn_data, nn_out;
  logic [1:0]  nn_sel;
  logic        busy, res_valid, done;
  logic [31:0] res_data;

  logic [7:0]  out_base = 8'hA0;
  assign nn_out = out_base + {6'd0, nn_sel};

  always #5 clk = ~clk;

  nn_host_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .nn_data    (nn_data),
    .nn_we      (nn_we),
    .nn_changes (nn_changes),
    .nn_sel     (nn_sel),
    .nn_out     (nn_out),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .done       (done)
  );

  typedef struct {
    int         rel;
    logic [1:0] sel;
  } sel_t;

  logic [7:0]  src_q[$];
  logic [7:0]  we_q[$];
  int          chg_q[$];
  logic [31:0] res_q[$];
  sel_t        sel_q[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int t0     = 0;
  int acc    = 0;
  int pulses = 0;
  bit tog, toggle_mode, overlap, will_acc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic bad(input string name,
                     input logic [31:0] act);
    total++;
    $display("FAIL %s: unexpected event, value %h", name, act);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    in_data = (src_q.size() > 0) ? src_q[0] : 8'hEE;
    if (!toggle_mode) begin
      in_valid = 1'b1;
    end else begin
      in_valid = in_ready & tog;
      if (in_ready) tog = ~tog;
    end
    will_acc = in_valid & in_ready;
  end

  always @(posedge clk) begin
    if (!reset && will_acc && src_q.size() > 0) begin
      void'(src_q.pop_front());
      acc++;
    end
  end

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0 + 1;
    if (nn_we && nn_changes) overlap = 1'b1;
    if (nn_we) begin
      if (we_q.size() == 0) bad("we_extra", {24'd0, nn_data});
      else chk("we_byte", {24'd0, nn_data},
               {24'd0, we_q.pop_front()});
    end
    if (nn_changes) begin
      pulses++;
      if (chg_q.size() == 0) bad("chg_extra", rel);
      else chk("chg_cycle", rel, chg_q.pop_front());
    end
    if (sel_q.size() > 0 && rel == sel_q[0].rel) begin
      sel_t s;
      s = sel_q.pop_front();
      chk("sel_seq", {30'd0, nn_sel}, {30'd0, s.sel});
    end
    if (res_valid) begin
      if (res_q.size() == 0) bad("res_extra", res_data);
      else chk("res_data", res_data, res_q.pop_front());
      chk("done_lvl", {31'd0, done}, 32'd1);
      chk("busy_low", {31'd0, busy}, 32'd0);
      chk("pulse_cnt", pulses, 4);
      chk("we_chg_excl", {31'd0, overlap}, 32'd0);
      pulses  = 0;
      overlap = 1'b0;
    end
  end

  task automatic begin_txn();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] b0,
                         input bit         tmode,
                         input logic [7:0] base,
                         input bit         noisy);
    int dp, e;
    bit hit;
    dp = tmode ? 24 : 0;
    e  = tmode ? 28 : 0;
    toggle_mode = tmode;
    tog      = 1'b0;
    out_base = base;
    pulses   = 0;
    overlap  = 1'b0;
    for (int i = 0; i < 28; i++) begin
      src_q.push_back(b0 + 8'(i));
      we_q.push_back(b0 + 8'(i));
    end
    chg_q.push_back(26 + dp);
    chg_q.push_back(31 + e);
    chg_q.push_back(42 + e);
    chg_q.push_back(44 + e);
    for (int j = 0; j < 8; j++)
      sel_q.push_back('{rel: 33 + e + j, sel: 2'(j / 2)});
    res_q.push_back({base + 8'd3, base + 8'd2,
                     base + 8'd1, base});
    begin_txn();
    if (noisy) begin
      repeat (26) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (res_valid) hit = 1'b1;
    end
    if (!hit) bad("res_timeout", 0);
    chk("res_cycle", cyc - t0 + 1, 46 + e);
    repeat (3) @(negedge clk);
    chk("we_drain", we_q.size(), 0);
    chk("chg_drain", chg_q.size(), 0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},  {31'd0, nn_we}, 32'd0);
    chk({tag, "_chg"}, {31'd0, nn_changes}, 32'd0);
    chk({tag, "_sel"}, {30'd0, nn_sel}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rv"},  {31'd0, res_valid}, 32'd0);
    chk({tag, "_rd"},  res_data, 32'd0);
    chk({tag, "_dat"}, {24'd0, nn_data}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    reset = 1'b1;
    start = 1'b0;
    toggle_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    run_txn(8'h01, 1'b0, 8'hA0, 1'b0);
    run_txn(8'h01, 1'b0, 8'hA0, 1'b0);
    run_txn(8'h61, 1'b1, 8'h50, 1'b0);
    run_txn(8'h01, 1'b0, 8'hA0, 1'b1);

    toggle_mode = 1'b0;
    acc = 0;
    for (int i = 0; i < 24; i++) begin
      src_q.push_back(8'hC0 + 8'(i));
      we_q.push_back(8'hC0 + 8'(i));
    end
    begin_txn();
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (acc >= 10) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) bad("acc_timeout", acc);
    chk("acc_at_rst", acc, 10);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort");
    src_q.delete();
    we_q.delete();
    pulses  = 0;
    overlap = 1'b0;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_quiet", pulses, 0);
    run_txn(8'h81, 1'b0, 8'h10, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
